temporizador_de_notas: RTL and testbench

Parametrised note-duration timer for the melody player; generalises the fixed-period toggle timer. Per note it times a programmable number of base beat units followed by an optional articulation gap, with start/busy/done handshake, pause and abort. The sequencer drives it on clk_divisor. The tone generator uses sonando as its gate. cambiar_nota stays available as a legacy toggle.

---
 rtl/temporizador_de_notas_if.sv | 24 ++
 rtl/temporizador_de_notas.sv | 111 +++++++++++
 tb/tb_temporizador_de_notas.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/temporizador_de_notas_if.sv
// Handshake bundle between the melody sequencer (master) and the note-duration timer (slave).
// Carries the start/pause/abort controls in one direction and the status/gate outputs in the other.
interface temporizador_de_notas_if #(
   parameter int DUR_W = 4
);
   logic             iniciar;
   logic [DUR_W-1:0] duracion;
   logic             pausa;
   logic             detener;
   logic             ocupado;
   logic             sonando;
   logic             fin_nota;
   logic             cambiar_nota;

   modport master (
      output iniciar, duracion, pausa, detener,
      input  ocupado, sonando, fin_nota, cambiar_nota
   );

   modport slave (
      input  iniciar, duracion, pausa, detener,
      output ocupado, sonando, fin_nota, cambiar_nota
   );
endinterface

// File: rtl/temporizador_de_notas.sv
// Note-duration timer: times duracion base units of TICK_CICLOS cycles, then an optional
// GAP_CICLOS articulation silence, with start/busy/done handshake, pause and abort.
module temporizador_de_notas #(
   parameter int CNT_W       = 23,
   parameter int TICK_CICLOS = 1500000,
   parameter int GAP_CICLOS  = 0,
   parameter int DUR_W       = 4
) (
   input logic                   clk_divisor,
   input logic                   reset,
   temporizador_de_notas_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SONANDO  = 2'd1,
      SILENCIO = 2'd2
   } estado_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CICLOS - 1);
   localparam int               GAP_FIN   = (GAP_CICLOS > 0) ? GAP_CICLOS - 1 : 0;
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FIN);

   estado_t          estado;
   logic [CNT_W-1:0] cont;
   logic [DUR_W-1:0] unidades;
   logic [DUR_W-1:0] dur_lat;
   logic             fin_nota;
   logic             cambiar_nota;

   logic             fin_unidad;
   logic             ultima_unidad;
   logic             completa;
   logic [DUR_W-1:0] dur_nueva;

   // A completion edge is either the last unit of a legato note or the last gap cycle.
   always_comb begin
      fin_unidad    = (cont == TICK_LAST);
      ultima_unidad = fin_unidad && (unidades == (dur_lat - DUR_W'(1)));
      completa      = ((estado == SONANDO) && ultima_unidad && (GAP_CICLOS == 0)) ||
                      ((estado == SILENCIO) && (cont == GAP_LAST));
      dur_nueva     = (bus.duracion == '0) ? DUR_W'(1) : bus.duracion;
   end

   // Abort beats pause, pause beats everything else; a paused completion simply waits.
   always_ff @(posedge clk_divisor or posedge reset) begin
      if (reset) begin
         estado       <= IDLE;
         cont         <= '0;
         unidades     <= '0;
         dur_lat      <= '0;
         fin_nota     <= 1'b0;
         cambiar_nota <= 1'b0;
      end else begin
         fin_nota <= 1'b0;
         if (bus.detener) begin
            estado   <= IDLE;
            cont     <= '0;
            unidades <= '0;
         end else if (bus.pausa && (estado != IDLE)) begin
            estado <= estado;
         end else if (completa) begin
            fin_nota     <= 1'b1;
            cambiar_nota <= ~cambiar_nota;
            cont         <= '0;
            unidades     <= '0;
            if (bus.iniciar) begin
               estado  <= SONANDO;
               dur_lat <= dur_nueva;
            end else begin
               estado <= IDLE;
            end
         end else begin
            case (estado)
               IDLE: begin
                  if (bus.iniciar) begin
                     estado   <= SONANDO;
                     dur_lat  <= dur_nueva;
                     cont     <= '0;
                     unidades <= '0;
                  end
               end
               SONANDO: begin
                  if (ultima_unidad) begin
                     estado   <= SILENCIO;
                     cont     <= '0;
                     unidades <= '0;
                  end else if (fin_unidad) begin
                     cont     <= '0;
                     unidades <= unidades + DUR_W'(1);
                  end else begin
                     cont <= cont + CNT_W'(1);
                  end
               end
               SILENCIO: begin
                  cont <= cont + CNT_W'(1);
               end
               default: begin
                  estado <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ocupado      = (estado != IDLE);
   assign bus.sonando      = (estado == SONANDO);
   assign bus.fin_nota     = fin_nota;
   assign bus.cambiar_nota = cambiar_nota;

endmodule

// File: tb/tb_temporizador_de_notas.sv
// Directed bench for temporizador_de_notas: a legato instance (GAP=0) and a gapped instance
// (GAP=2), both with TICK=4, driven by a linear sequence of steps with hand-computed results.
module tb_temporizador_de_notas;

   logic clk;
   logic reset_a;
   logic reset_b;
   int   compared;
   int   mismatched;

   temporizador_de_notas_if #(.DUR_W(4)) ia ();
   temporizador_de_notas_if #(.DUR_W(4)) ib ();

   temporizador_de_notas #(
      .CNT_W(23), .TICK_CICLOS(4), .GAP_CICLOS(0), .DUR_W(4)
   ) dut_a (
      .clk_divisor(clk),
      .reset(reset_a),
      .bus(ia)
   );

   temporizador_de_notas #(
      .CNT_W(23), .TICK_CICLOS(4), .GAP_CICLOS(2), .DUR_W(4)
   ) dut_b (
      .clk_divisor(clk),
      .reset(reset_b),
      .bus(ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle 1 time unit past it before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_a    = 1'b1;
      reset_b    = 1'b1;
      ia.iniciar = 1'b0; ia.duracion = '0; ia.pausa = 1'b0; ia.detener = 1'b0;
      ib.iniciar = 1'b0; ib.duracion = '0; ib.pausa = 1'b0; ib.detener = 1'b0;

      #2;
      checkOutput("rst_ocupado", ia.ocupado, 1'b0);
      checkOutput("rst_sonando", ia.sonando, 1'b0);
      checkOutput("rst_fin", ia.fin_nota, 1'b0);
      checkOutput("rst_cambiar", ia.cambiar_nota, 1'b0);
      #10;
      reset_a = 1'b0;
      reset_b = 1'b0;

      // Legato note of 3 units: 12 sounding cycles, pulse on the 13th edge after start.
      ia.duracion = 4'd3;
      ia.iniciar  = 1'b1;
      step();
      ia.iniciar = 1'b0;
      checkOutput("t1_ocupado_start", ia.ocupado, 1'b1);
      checkOutput("t1_sonando_c1", ia.sonando, 1'b1);
      for (int k = 2; k <= 12; k++) begin
         step();
         checkOutput($sformatf("t1_sonando_c%0d", k), ia.sonando, 1'b1);
         checkOutput($sformatf("t1_fin_c%0d", k), ia.fin_nota, 1'b0);
      end
      step();
      checkOutput("t1_fin_pulse", ia.fin_nota, 1'b1);
      checkOutput("t1_sonando_end", ia.sonando, 1'b0);
      checkOutput("t1_ocupado_end", ia.ocupado, 1'b0);
      checkOutput("t1_cambiar", ia.cambiar_nota, 1'b1);
      step();
      checkOutput("t1_fin_single", ia.fin_nota, 1'b0);

      // duracion=0 acts as 1 unit; then 2 gap cycles before completion.
      ib.duracion = 4'd0;
      ib.iniciar  = 1'b1;
      step();
      ib.iniciar = 1'b0;
      checkOutput("t2_sonando_c1", ib.sonando, 1'b1);
      for (int k = 2; k <= 4; k++) begin
         step();
         checkOutput($sformatf("t2_sonando_c%0d", k), ib.sonando, 1'b1);
      end
      step();
      checkOutput("t2_gap1_sonando", ib.sonando, 1'b0);
      checkOutput("t2_gap1_ocupado", ib.ocupado, 1'b1);
      step();
      checkOutput("t2_gap2_ocupado", ib.ocupado, 1'b1);
      checkOutput("t2_gap2_fin", ib.fin_nota, 1'b0);
      step();
      checkOutput("t2_fin_pulse", ib.fin_nota, 1'b1);
      checkOutput("t2_ocupado_end", ib.ocupado, 1'b0);
      checkOutput("t2_cambiar", ib.cambiar_nota, 1'b1);

      // Chaining: 2-unit note followed back-to-back by a 1-unit note.
      reset_a = 1'b1;
      #2;
      reset_a = 1'b0;
      checkOutput("t3_cambiar_rst", ia.cambiar_nota, 1'b0);
      ia.duracion = 4'd2;
      ia.iniciar  = 1'b1;
      step();
      ia.duracion = 4'd1;
      for (int k = 2; k <= 8; k++) begin
         step();
         checkOutput($sformatf("t3_sonando_c%0d", k), ia.sonando, 1'b1);
      end
      step();
      checkOutput("t3_fin1", ia.fin_nota, 1'b1);
      checkOutput("t3_sonando_chain", ia.sonando, 1'b1);
      checkOutput("t3_ocupado_chain", ia.ocupado, 1'b1);
      checkOutput("t3_cambiar1", ia.cambiar_nota, 1'b1);
      ia.iniciar = 1'b0;
      for (int k = 10; k <= 12; k++) begin
         step();
         checkOutput($sformatf("t3_sonando_c%0d", k), ia.sonando, 1'b1);
         checkOutput($sformatf("t3_fin_c%0d", k), ia.fin_nota, 1'b0);
      end
      step();
      checkOutput("t3_fin2", ia.fin_nota, 1'b1);
      checkOutput("t3_ocupado_end", ia.ocupado, 1'b0);
      checkOutput("t3_cambiar2", ia.cambiar_nota, 1'b0);

      // Pause for 5 cycles from cycle 3 of a 2-unit note: completion slips by 5.
      ia.duracion = 4'd2;
      ia.iniciar  = 1'b1;
      step();
      ia.iniciar = 1'b0;
      step();
      step();
      ia.pausa = 1'b1;
      for (int k = 4; k <= 8; k++) begin
         step();
         checkOutput($sformatf("t4_paused_sonando_c%0d", k), ia.sonando, 1'b1);
         checkOutput($sformatf("t4_paused_fin_c%0d", k), ia.fin_nota, 1'b0);
      end
      ia.pausa = 1'b0;
      for (int k = 9; k <= 13; k++) begin
         step();
         checkOutput($sformatf("t4_sonando_c%0d", k), ia.sonando, 1'b1);
         checkOutput($sformatf("t4_fin_c%0d", k), ia.fin_nota, 1'b0);
      end
      step();
      checkOutput("t4_fin_pulse", ia.fin_nota, 1'b1);
      checkOutput("t4_sonando_end", ia.sonando, 1'b0);
      checkOutput("t4_cambiar", ia.cambiar_nota, 1'b1);

      // Abort mid-note at cycle 6 of an 8-cycle note.
      ia.iniciar = 1'b1;
      step();
      ia.iniciar = 1'b0;
      for (int k = 2; k <= 6; k++) step();
      ia.detener = 1'b1;
      step();
      ia.detener = 1'b0;
      checkOutput("t5_abort_sonando", ia.sonando, 1'b0);
      checkOutput("t5_abort_ocupado", ia.ocupado, 1'b0);
      checkOutput("t5_abort_fin", ia.fin_nota, 1'b0);
      checkOutput("t5_abort_cambiar", ia.cambiar_nota, 1'b1);
      step();
      checkOutput("t5_abort_fin_late", ia.fin_nota, 1'b0);

      // Abort landing exactly on the completion edge suppresses the pulse.
      ia.iniciar = 1'b1;
      step();
      ia.iniciar = 1'b0;
      for (int k = 2; k <= 8; k++) step();
      checkOutput("t5b_sonando_c8", ia.sonando, 1'b1);
      ia.detener = 1'b1;
      step();
      ia.detener = 1'b0;
      checkOutput("t5b_fin", ia.fin_nota, 1'b0);
      checkOutput("t5b_ocupado", ia.ocupado, 1'b0);
      checkOutput("t5b_cambiar", ia.cambiar_nota, 1'b1);
      step();
      checkOutput("t5b_fin_late", ia.fin_nota, 1'b0);

      // Asynchronous reset between edges while in SILENCIO, then a fresh full note.
      ib.duracion = 4'd1;
      ib.iniciar  = 1'b1;
      step();
      ib.iniciar = 1'b0;
      for (int k = 2; k <= 5; k++) step();
      checkOutput("t6_silencio_ocupado", ib.ocupado, 1'b1);
      checkOutput("t6_silencio_sonando", ib.sonando, 1'b0);
      #2;
      reset_b = 1'b1;
      #1;
      checkOutput("t6_rst_ocupado", ib.ocupado, 1'b0);
      checkOutput("t6_rst_sonando", ib.sonando, 1'b0);
      checkOutput("t6_rst_fin", ib.fin_nota, 1'b0);
      checkOutput("t6_rst_cambiar", ib.cambiar_nota, 1'b0);
      #1;
      reset_b = 1'b0;
      ib.duracion = 4'd2;
      ib.iniciar  = 1'b1;
      step();
      ib.iniciar = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         checkOutput($sformatf("t6_sonando_c%0d", k), ib.sonando, 1'b1);
         step();
      end
      checkOutput("t6_sonando_c8", ib.sonando, 1'b1);
      step();
      checkOutput("t6_gap1_sonando", ib.sonando, 1'b0);
      checkOutput("t6_gap1_ocupado", ib.ocupado, 1'b1);
      step();
      checkOutput("t6_gap2_ocupado", ib.ocupado, 1'b1);
      checkOutput("t6_gap2_fin", ib.fin_nota, 1'b0);
      step();
      checkOutput("t6_fin_pulse", ib.fin_nota, 1'b1);
      checkOutput("t6_ocupado_end", ib.ocupado, 1'b0);
      checkOutput("t6_cambiar", ib.cambiar_nota, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
